// File: rtl/miriscv_lsu.sv
// MIRISCV load/store unit: request/grant/response sequencing toward data memory.
// Define MIRISCV_LSU_MISALIGN_EXC_EN to flag misaligned H/W accesses instead of forcing alignment.
module miriscv_lsu (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_misalign_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_e;
   state_e state_q, state_d;

   // size[1:0]: 00 byte, 01 half, anything else word (covers 3, 6, 7)
   logic is_b, is_h, is_u;
   assign is_b = (lsu_size_i[1:0] == 2'b00);
   assign is_h = (lsu_size_i[1:0] == 2'b01);
   assign is_u = lsu_size_i[2];

   logic misalign, legal;
`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
   assign misalign = (is_h & lsu_addr_i[0]) |
                     (~is_b & ~is_h & (lsu_addr_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign legal          = ~misalign;
   assign lsu_misalign_o = lsu_req_i & misalign;

   logic done;
   assign done = (state_q == RESP) & data_rvalid_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (lsu_req_i & legal) state_d = data_gnt_i ? RESP : REQ;
         REQ:     if (data_gnt_i)        state_d = RESP;
         RESP:    if (data_rvalid_i)     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) state_q <= IDLE;
      else          state_q <= state_d;
   end

   assign data_req_o      = ((state_q == IDLE) & lsu_req_i & legal) | (state_q == REQ);
   assign data_we_o       = data_req_o & lsu_we_i;
   assign data_addr_o     = {lsu_addr_i[31:2], 2'b00};
   assign lsu_stall_req_o = lsu_req_i & legal & ~done;

   logic [3:0]  be;
   logic [31:0] wdata;
   always_comb begin
      if (is_b) begin
         be    = 4'b0001 << lsu_addr_i[1:0];
         wdata = {4{lsu_data_i[7:0]}};
      end else if (is_h) begin
         be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
         wdata = {2{lsu_data_i[15:0]}};
      end else begin
         be    = 4'b1111;
         wdata = lsu_data_i;
      end
   end
   assign data_be_o    = data_req_o ? be    : 4'b0000;
   assign data_wdata_o = data_req_o ? wdata : 32'h0;

   logic [7:0]  rbyte;
   logic [15:0] rhalf;
   logic [31:0] rext;
   assign rbyte = 8'(data_rdata_i >> {lsu_addr_i[1:0], 3'b000});
   assign rhalf = lsu_addr_i[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];

   always_comb begin
      if (is_b)      rext = {{24{~is_u & rbyte[7]}}, rbyte};
      else if (is_h) rext = {{16{~is_u & rhalf[15]}}, rhalf};
      else           rext = data_rdata_i;
   end
   // Only a load's completion cycle exposes read data; everything else reads as 0.
   assign lsu_data_o = (done & ~lsu_we_i) ? rext : 32'h0;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed self-checking bench for miriscv_lsu.
module tb_miriscv_lsu;
   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        lsu_req_i, lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i, lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o, lsu_misalign_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;

   miriscv_lsu dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_size_i(lsu_size_i),
      .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_data_o(lsu_data_o),
      .lsu_stall_req_o(lsu_stall_req_o), .lsu_misalign_o(lsu_misalign_o),
      .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle_in();
      lsu_req_i = 0; lsu_we_i = 0; lsu_size_i = 3'd2; lsu_addr_i = 0; lsu_data_i = 0;
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = 0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req"},   32'(data_req_o), 0);
      chk({tag, "_we"},    32'(data_we_o), 0);
      chk({tag, "_be"},    32'(data_be_o), 0);
      chk({tag, "_wdata"}, data_wdata_o, 0);
      chk({tag, "_stall"}, 32'(lsu_stall_req_o), 0);
      chk({tag, "_mis"},   32'(lsu_misalign_o), 0);
      chk({tag, "_ldata"}, lsu_data_o, 0);
   endtask

   // One access: gd cycles without grant, grant cycle, rw RESP wait cycles, completion.
   // Entered and left at posedge+1.
   task automatic acc(input string tag, input logic we, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                      input int gd, input int rw, input logic [31:0] eaddr,
                      input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
      int stalls = 0;
      lsu_req_i = 1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = a; lsu_data_i = d;
      data_rvalid_i = 0;
      for (int c = 0; c <= gd; c++) begin
         data_gnt_i = (c == gd);
         #3;
         chk({tag, "_req"},   32'(data_req_o), 1);
         chk({tag, "_we"},    32'(data_we_o), 32'(we));
         chk({tag, "_addr"},  data_addr_o, eaddr);
         chk({tag, "_be"},    32'(data_be_o), 32'(ebe));
         chk({tag, "_wdata"}, data_wdata_o, ewd);
         chk({tag, "_mis"},   32'(lsu_misalign_o), 0);
         if (lsu_stall_req_o) stalls++;
         @(posedge clk_i); #1;
      end
      data_gnt_i = 0;
      for (int c = 0; c <= rw; c++) begin
         data_rvalid_i = (c == rw);
         data_rdata_i  = (c == rw) ? rd : 32'h5A5A_5A5A;
         #3;
         chk({tag, "_rsp_req"}, 32'(data_req_o), 0);
         if (c < rw) chk({tag, "_wait_ldata"}, lsu_data_o, 0);
         else if (!we) chk({tag, "_ldata"}, lsu_data_o, eld);
         if (lsu_stall_req_o) stalls++;
         @(posedge clk_i); #1;
      end
      chk({tag, "_stall_cycles"}, 32'(stalls), 32'(gd + rw + 1));
      idle_in();
   endtask

   initial begin
      idle_in();
      arstn_i = 0;
      #12;
      chk_reset_outs("reset");
      @(posedge clk_i); #1;
      arstn_i = 1;
      @(posedge clk_i); #1;

      acc("lw104",  0, 3'd2, 32'h104, 0, 32'hDEADBEEF, 0, 0, 32'h104, 4'hF, 32'h0, 32'hDEADBEEF);
      acc("lb203",  0, 3'd0, 32'h203, 0, 32'h80FF0000, 0, 0, 32'h200, 4'b1000, 32'h0, 32'hFFFFFF80);
      acc("lbu203", 0, 3'd4, 32'h203, 0, 32'h80FF0000, 0, 0, 32'h200, 4'b1000, 32'h0, 32'h00000080);
      acc("sh302",  1, 3'd1, 32'h302, 32'h1234ABCD, 0, 3, 1, 32'h300, 4'b1100, 32'hABCDABCD, 0);
      acc("lh202",  0, 3'd1, 32'h202, 0, 32'h80017FFF, 1, 2, 32'h200, 4'b1100, 32'h0, 32'hFFFF8001);
      acc("lhu200", 0, 3'd5, 32'h200, 0, 32'h80018FFF, 0, 0, 32'h200, 4'b0011, 32'h0, 32'h00008FFF);
      acc("sb301",  1, 3'd0, 32'h301, 32'h000000A5, 0, 0, 0, 32'h300, 4'b0010, 32'hA5A5A5A5, 0);
      // Back-to-back stores: second request must appear the cycle after completion
      acc("sw_a",   1, 3'd2, 32'h400, 32'h11223344, 0, 0, 0, 32'h400, 4'hF, 32'h11223344, 0);
      acc("sw_b",   1, 3'd2, 32'h404, 32'h55667788, 0, 0, 0, 32'h404, 4'hF, 32'h55667788, 0);

      // Reset while in RESP, then a stray rvalid
      lsu_req_i = 1; lsu_size_i = 3'd2; lsu_addr_i = 32'h500; data_gnt_i = 1;
      #3; chk("rst_pre_req", 32'(data_req_o), 1);
      @(posedge clk_i); #1;
      idle_in();
      arstn_i = 0;
      #3; chk_reset_outs("rst_mid");
      @(posedge clk_i); #1;
      arstn_i = 1;
      data_rvalid_i = 1; data_rdata_i = 32'hCAFEF00D;
      #3; chk_reset_outs("rst_stray");
      @(posedge clk_i); #1;
      idle_in();
      acc("lw_after_rst", 0, 3'd2, 32'h600, 0, 32'h0BADF00D, 0, 0, 32'h600, 4'hF, 32'h0, 32'h0BADF00D);

`ifdef MIRISCV_LSU_MISALIGN_EXC_EN
      lsu_req_i = 1; lsu_size_i = 3'd2; lsu_addr_i = 32'h101; data_gnt_i = 1;
      #3;
      chk("mis_flag",  32'(lsu_misalign_o), 1);
      chk("mis_req",   32'(data_req_o), 0);
      chk("mis_stall", 32'(lsu_stall_req_o), 0);
      @(posedge clk_i); #1;
      idle_in();
      #3; chk("mis_clear", 32'(lsu_misalign_o), 0);
      @(posedge clk_i); #1;
`else
      acc("lw101", 0, 3'd2, 32'h101, 0, 32'h89ABCDEF, 0, 0, 32'h100, 4'hF, 32'h0, 32'h89ABCDEF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
